// File: rtl/coef_demux4.sv
// Coefficient demultiplexer: packs a stream of 16-bit coefficients into groups of up to
// four lanes (a..d). Optional build macro COEF_DEMUX4_MODQ_EN reduces values >= 3329 once.
module coef_demux4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_c,
    output logic [15:0] out_d,
    output logic [2:0]  out_cnt,
    output logic        out_valid,
    input  logic        out_ready
);

`ifdef COEF_DEMUX4_MODQ_EN
    localparam logic [15:0] MODQ = 16'd3329;
`endif

    function automatic logic [15:0] reduce(input logic [15:0] v);
`ifdef COEF_DEMUX4_MODQ_EN
        return (v >= MODQ) ? v - MODQ : v;
`else
        return v;
`endif
    endfunction

    logic [1:0]  cnt;
    logic [15:0] col_a, col_b, col_c;
    logic [15:0] din;
    logic [15:0] nxt_a, nxt_b, nxt_c, nxt_d;
    logic        complete;
    logic        accept;
    logic        out_hs;

    assign din      = reduce(in_data);
    assign complete = in_valid && ((cnt == 2'd3) || in_last);
    // Only a completing coefficient needs the output registers, so only it can stall.
    assign in_ready = !(complete && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // NOTE: every combinational output is given a default first so no latch is inferred.
    always_comb begin
        nxt_a = din;
        nxt_b = 16'h0000;
        nxt_c = 16'h0000;
        nxt_d = 16'h0000;
        case (cnt)
            2'd0: nxt_a = din;
            2'd1: begin
                nxt_a = col_a;
                nxt_b = din;
            end
            2'd2: begin
                nxt_a = col_a;
                nxt_b = col_b;
                nxt_c = din;
            end
            2'd3: begin
                nxt_a = col_a;
                nxt_b = col_b;
                nxt_c = col_c;
                nxt_d = din;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            col_a     <= 16'h0000;
            col_b     <= 16'h0000;
            col_c     <= 16'h0000;
            out_a     <= 16'h0000;
            out_b     <= 16'h0000;
            out_c     <= 16'h0000;
            out_d     <= 16'h0000;
            out_cnt   <= 3'd0;
            out_valid <= 1'b0;
        end else if (accept && complete) begin
            // Completion overrides any same-cycle output handshake: the new group replaces it.
            out_a     <= nxt_a;
            out_b     <= nxt_b;
            out_c     <= nxt_c;
            out_d     <= nxt_d;
            out_cnt   <= {1'b0, cnt} + 3'd1;
            out_valid <= 1'b1;
            cnt       <= 2'd0;
        end else begin
            if (accept) begin
                case (cnt)
                    2'd0:    col_a <= din;
                    2'd1:    col_b <= din;
                    2'd2:    col_c <= din;
                    default: ;
                endcase
                cnt <= cnt + 2'd1;
            end
            if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_coef_demux4.sv
// Self-checking bench for coef_demux4: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_coef_demux4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d;
    logic [2:0]  out_cnt;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    coef_demux4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of pending coefficients and the group currently presented.
    logic [15:0] pend[$];
    logic [15:0] exp_lane[4];
    logic [2:0]  exp_cnt;
    bit          exp_valid;

    function automatic logic [15:0] m_reduce(input logic [15:0] v);
`ifdef COEF_DEMUX4_MODQ_EN
        if (v >= 16'd3329) return v - 16'd3329;
`endif
        return v;
    endfunction

    function automatic bit exp_in_ready();
        return !(in_valid && (pend.size() == 3 || in_last) && exp_valid && !out_ready);
    endfunction

    always @(posedge clk) begin
        bit done;
        bit hs;
        done = 1'b0;
        hs   = exp_valid && out_ready;
        if (!rst_n) begin
            pend.delete();
            exp_valid = 1'b0;
            exp_cnt   = 3'd0;
            for (int i = 0; i < 4; i++) exp_lane[i] = 16'h0000;
        end else begin
            if (in_valid && exp_in_ready()) begin
                pend.push_back(m_reduce(in_data));
                if (pend.size() == 4 || in_last) begin
                    for (int i = 0; i < 4; i++)
                        exp_lane[i] = (i < pend.size()) ? pend[i] : 16'h0000;
                    exp_cnt   = 3'(pend.size());
                    exp_valid = 1'b1;
                    pend.delete();
                    done = 1'b1;
                end
            end
            if (!done && hs) exp_valid = 1'b0;
        end
    end

    // Compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", in_ready, exp_in_ready());
            check("cmp_out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                check("cmp_out_a", out_a, exp_lane[0]);
                check("cmp_out_b", out_b, exp_lane[1]);
                check("cmp_out_c", out_c, exp_lane[2]);
                check("cmp_out_d", out_d, exp_lane[3]);
                check("cmp_out_cnt", out_cnt, exp_cnt);
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit last);
        int w;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            stalls++;
            @(negedge clk);
        end
        if (w >= 50) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_group(input string name, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d, input logic [2:0] n);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_a"}, out_a, a);
        check({name, "_b"}, out_b, b);
        check({name, "_c"}, out_c, c);
        check({name, "_d"}, out_d, d);
        check({name, "_cnt"}, out_cnt, n);
    endtask

    initial begin
        int c1, c2;
        rst_n     = 1'b0;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_d", out_d, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Full group of four
        out_ready = 1'b1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        @(negedge clk);
        expect_group("full", 1, 2, 3, 4, 4);
        @(posedge clk); #1;

        // Short group closed by in_last, then next coefficient lands in lane a
        send(10, 0); send(20, 1);
        @(negedge clk);
        expect_group("short", 10, 20, 0, 0, 2);
        @(posedge clk); #1;
        send(30, 1);
        @(negedge clk);
        expect_group("after_short", 30, 0, 0, 0, 1);
        @(posedge clk); #1;

        // Backpressure: completing coefficient stalls until out_ready rises
        out_ready = 1'b0;
        send(40, 1);
        send(5, 0); send(6, 0); send(7, 0);
        in_data = 8; in_last = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold_a", out_a, 40);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        expect_group("bp_replace", 5, 6, 7, 8, 4);
        @(posedge clk); #1;

        // Back-to-back single-lane groups: replace with no bubble
        send(1, 1); send(2, 1); send(3, 1);
        @(negedge clk);
        expect_group("replace", 3, 0, 0, 0, 1);
        @(posedge clk); #1;

        // Continuous stream of eight: no stalls, groups four cycles apart
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'(100 + i), 0);
            if (i == 3) c1 = cyc;
            if (i == 7) c2 = cyc;
        end
        @(negedge clk);
        expect_group("stream2", 104, 105, 106, 107, 4);
        check("stream_stalls", stalls, 0);
        check("stream_spacing", c2 - c1, 4);
        @(posedge clk); #1;

        // Reset mid-group discards the partial group
        send(21, 0); send(22, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_cnt", out_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(9, 0); send(9, 0); send(9, 0); send(9, 0);
        @(negedge clk);
        expect_group("midrst", 9, 9, 9, 9, 4);
        @(posedge clk); #1;

        // Modular reduction boundary values
        send(3328, 0); send(3329, 0); send(6657, 0); send(65535, 0);
        @(negedge clk);
`ifdef COEF_DEMUX4_MODQ_EN
        expect_group("modq", 3328, 0, 3328, 62206, 4);
`else
        expect_group("modq", 3328, 3329, 6657, 65535, 4);
`endif
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t required below 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
